// File: rtl/exec_opcode_history.sv
`default_nettype none
// ============================================================================
// Module      : exec_opcode_history
// Description : Retired-instruction observer for the PDP-8 execute stage.
//               Classifies every retired 12-bit instruction word into a
//               4-bit opcode-class code and keeps a shift-register history
//               of the last DEPTH classes. It raises an observation flag per
//               retirement for a downstream coverage monitor. It also counts
//               retirements and overruns, where an overrun is a retirement
//               that arrives while the previous observation is still
//               unconsumed.
//
// Ports       : clk           - system clock
//               reset_n       - asynchronous active-low reset
//               instr_valid   - an instruction retired this cycle
//               instr         - retired instruction word
//               hist_flush    - synchronous clear of history and counters
//               obs_clear     - consumer acknowledges current observation
//               obs_flag      - unconsumed observation pending
//               hist_flat     - class history, [3:0] newest
//               hist_count    - valid history entries, saturates at DEPTH
//               last_class    - class of the most recent capture
//               retire_count  - captured retirements, wraps
//               overrun_count - overruns, saturates at all-ones
//
// Revision    : 1.0 - initial release
// ============================================================================
module exec_opcode_history #(
    parameter int DEPTH = 6,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid,
    input  logic [11:0]        instr,
    input  logic               hist_flush,
    input  logic               obs_clear,
    output logic               obs_flag,
    output logic [4*DEPTH-1:0] hist_flat,
    output logic [4:0]         hist_count,
    output logic [3:0]         last_class,
    output logic [CNT_W-1:0]   retire_count,
    output logic [CNT_W-1:0]   overrun_count
);

    // Opcode-class codes
    localparam logic [3:0] c_clsNop    = 4'd7;
    localparam logic [3:0] c_clsClaCll = 4'd8;
    localparam logic [3:0] c_clsHlt    = 4'd9;
    localparam logic [3:0] c_clsOpr1   = 4'd10;
    localparam logic [3:0] c_clsOpr2   = 4'd11;
    localparam logic [3:0] c_clsOpr3   = 4'd12;

    localparam logic [4:0] c_depthCnt  = 5'(DEPTH);

    logic [3:0]       r_hist [DEPTH];
    logic [4:0]       r_histCount;
    logic [CNT_W-1:0] r_retireCount;
    logic [CNT_W-1:0] r_overrunCount;
    logic             r_obsFlag;

    logic [3:0]       w_class;
    logic             w_capture;
    logic             w_overrun;

    // ------------------------------------------------------------------
    // Classification. Ops 0..6 map straight onto their class code; op 7
    // (operate) splits into group 1 / group 2 / group 3 microcodes with a
    // few exact words given their own classes.
    // ------------------------------------------------------------------
    always_comb begin
        w_class = 4'd0;
        if (instr[11:9] != 3'd7) begin
            w_class = {1'b0, instr[11:9]};
        end else if (!instr[8]) begin
            if (instr == 12'o7000)
                w_class = c_clsNop;
            else if (instr == 12'o7300)
                w_class = c_clsClaCll;
            else
                w_class = c_clsOpr1;
        end else if (!instr[0]) begin
            if (instr == 12'o7402)
                w_class = c_clsHlt;
            else
                w_class = c_clsOpr2;
        end else begin
            w_class = c_clsOpr3;
        end
    end

    // Flush wins over a simultaneous retirement, which is then dropped.
    assign w_capture = instr_valid && !hist_flush;
    // A clear in the same cycle as a capture consumes the old observation,
    // so only an unacknowledged pending observation counts as an overrun.
    assign w_overrun = w_capture && r_obsFlag && !obs_clear;

    // ------------------------------------------------------------------
    // History shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_hist[i] <= 4'd0;
        end else if (hist_flush) begin
            for (int i = 0; i < DEPTH; i++)
                r_hist[i] <= 4'd0;
        end else if (w_capture) begin
            r_hist[0] <= w_class;
            for (int i = 1; i < DEPTH; i++)
                r_hist[i] <= r_hist[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Counters and observation flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_histCount    <= 5'd0;
            r_retireCount  <= '0;
            r_overrunCount <= '0;
            r_obsFlag      <= 1'b0;
        end else if (hist_flush) begin
            r_histCount    <= 5'd0;
            r_retireCount  <= '0;
            r_overrunCount <= '0;
            r_obsFlag      <= 1'b0;
        end else begin
            if (w_capture) begin
                if (r_histCount != c_depthCnt)
                    r_histCount <= r_histCount + 5'd1;
                r_retireCount <= r_retireCount + 1'b1;
                r_obsFlag     <= 1'b1;
            end else if (obs_clear) begin
                r_obsFlag <= 1'b0;
            end

            if (w_overrun && (r_overrunCount != '1))
                r_overrunCount <= r_overrunCount + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign hist_flat[4*g +: 4] = r_hist[g];
    end

    assign last_class    = r_hist[0];
    assign hist_count    = r_histCount;
    assign retire_count  = r_retireCount;
    assign overrun_count = r_overrunCount;
    assign obs_flag      = r_obsFlag;

endmodule
`default_nettype wire

// File: tb/tb_exec_opcode_history.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_opcode_history
// Description : Scoreboard bench for exec_opcode_history. The driver issues
//               directed vectors and queues the hand-computed state expected
//               after each edge. A monitor on the falling edge pops and
//               compares these expectations against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_opcode_history;

    localparam int DEPTH = 6;
    localparam int CNT_W = 16;

    logic               clk;
    logic               reset_n;
    logic               instr_valid;
    logic [11:0]        instr;
    logic               hist_flush;
    logic               obs_clear;
    logic               obs_flag;
    logic [4*DEPTH-1:0] hist_flat;
    logic [4:0]         hist_count;
    logic [3:0]         last_class;
    logic [CNT_W-1:0]   retire_count;
    logic [CNT_W-1:0]   overrun_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            name;
        logic [23:0]      hist;
        logic [4:0]       cnt;
        logic [3:0]       last;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] ov;
        logic             flag;
    } exp_t;

    exp_t expQ[$];

    exec_opcode_history #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .hist_flush    (hist_flush),
        .obs_clear     (obs_clear),
        .obs_flag      (obs_flag),
        .hist_flat     (hist_flat),
        .hist_count    (hist_count),
        .last_class    (last_class),
        .retire_count  (retire_count),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string nm, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
        end
    endtask

    task automatic checkAll(input exp_t e);
        checkField(e.name, "hist_flat", 32'(hist_flat), 32'(e.hist));
        checkField(e.name, "hist_count", 32'(hist_count), 32'(e.cnt));
        checkField(e.name, "last_class", 32'(last_class), 32'(e.last));
        checkField(e.name, "retire_count", 32'(retire_count), 32'(e.ret));
        checkField(e.name, "overrun_count", 32'(overrun_count), 32'(e.ov));
        checkField(e.name, "obs_flag", 32'(obs_flag), 32'(e.flag));
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            checkAll(expQ.pop_front());
        end
    end

    // Drive one cycle of inputs, then queue the state expected after the edge.
    task automatic step(input string nm, input logic v, input logic [11:0] ins,
                        input logic fl, input logic clr,
                        input logic [23:0] h, input logic [4:0] c,
                        input logic [3:0] l, input logic [15:0] r,
                        input logic [15:0] o, input logic f);
        exp_t e;
        instr_valid = v;
        instr       = ins;
        hist_flush  = fl;
        obs_clear   = clr;
        @(posedge clk);
        #1;
        e.name = nm; e.hist = h; e.cnt = c; e.last = l;
        e.ret = r; e.ov = o; e.flag = f;
        expQ.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t z;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 12'o0;
        hist_flush  = 1'b0;
        obs_clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        z.name = "in_reset"; z.hist = '0; z.cnt = '0; z.last = '0;
        z.ret = '0; z.ov = '0; z.flag = 1'b0;
        checkAll(z);
        reset_n = 1'b1;

        step("idle", 0, 12'o0, 0, 0, 24'h000000, 0, 0, 0, 0, 0);

        // Retire sequence with a clear the cycle after every capture
        step("seq1", 1, 12'o7300, 0, 0, 24'h000008, 1, 8, 1, 0, 1);
        step("seq2", 1, 12'o1010, 0, 1, 24'h000081, 2, 1, 2, 0, 1);
        step("seq3", 1, 12'o1011, 0, 1, 24'h000811, 3, 1, 3, 0, 1);
        step("seq4", 1, 12'o3012, 0, 1, 24'h008113, 4, 3, 4, 0, 1);
        step("seq5", 1, 12'o7402, 0, 1, 24'h081139, 5, 9, 5, 0, 1);
        step("seq6", 1, 12'o5200, 0, 1, 24'h811395, 6, 5, 6, 0, 1);
        step("seq7", 0, 12'o0,    0, 1, 24'h811395, 6, 5, 6, 0, 0);

        // Classification plus history saturation over ten captures
        step("flushA", 0, 12'o0, 1, 0, 24'h000000, 0, 0, 0, 0, 0);
        step("cls0000", 1, 12'o0000, 0, 1, 24'h000000, 1, 4'h0, 1, 0, 1);
        step("cls2000", 1, 12'o2000, 0, 1, 24'h000002, 2, 4'h2, 2, 0, 1);
        step("cls4000", 1, 12'o4000, 0, 1, 24'h000024, 3, 4'h4, 3, 0, 1);
        step("cls6031", 1, 12'o6031, 0, 1, 24'h000246, 4, 4'h6, 4, 0, 1);
        step("cls7000", 1, 12'o7000, 0, 1, 24'h002467, 5, 4'h7, 5, 0, 1);
        step("cls7001", 1, 12'o7001, 0, 1, 24'h02467A, 6, 4'hA, 6, 0, 1);
        step("cls7402", 1, 12'o7402, 0, 1, 24'h2467A9, 6, 4'h9, 7, 0, 1);
        step("cls7410", 1, 12'o7410, 0, 1, 24'h467A9B, 6, 4'hB, 8, 0, 1);
        step("cls7401", 1, 12'o7401, 0, 1, 24'h67A9BC, 6, 4'hC, 9, 0, 1);
        step("cap10",   1, 12'o1000, 0, 1, 24'h7A9BC1, 6, 4'h1, 10, 0, 1);

        // Overrun handshake
        step("flushB", 0, 12'o0, 1, 0, 24'h000000, 0, 0, 0, 0, 0);
        step("ovr1", 1, 12'o0000, 0, 0, 24'h000000, 1, 0, 1, 0, 1);
        step("ovr2", 1, 12'o1000, 0, 0, 24'h000001, 2, 1, 2, 1, 1);
        step("ovr3", 1, 12'o2000, 0, 0, 24'h000012, 3, 2, 3, 2, 1);
        step("capClr", 1, 12'o3000, 0, 1, 24'h000123, 4, 3, 4, 2, 1);
        step("clrOnly", 0, 12'o0, 0, 1, 24'h000123, 4, 3, 4, 2, 0);

        // Flush beats a simultaneous capture
        step("flushCap", 1, 12'o5200, 1, 0, 24'h000000, 0, 0, 0, 0, 0);
        step("afterFl", 1, 12'o1000, 0, 0, 24'h000001, 1, 1, 1, 0, 1);
        step("preRst", 1, 12'o7000, 0, 0, 24'h000017, 2, 7, 2, 1, 1);

        // Asynchronous reset between edges with an observation pending
        instr_valid = 1'b0;
        obs_clear   = 1'b0;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        z.name = "asyncRst";
        checkAll(z);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("resume", 1, 12'o4000, 0, 0, 24'h000004, 1, 4, 1, 0, 1);
        step("tail", 0, 12'o0, 0, 1, 24'h000004, 1, 4, 1, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_opcode_history.md
Name: exec_opcode_history

Overview:
- Sits between the PDP-8 execute stage and the sequence-coverage monitor.
- Captures each retired instruction word, classifies it into a 4-bit opcode-class code, and keeps a shift-register history of the last DEPTH classes.
- Raises an observation flag per retirement that the downstream monitor consumes and clears.
- Counts retirements and counts overruns, i.e. retirements the consumer did not clear in time.

Parameters:
DEPTH, 6, history entries kept (legal 2..16)
CNT_W, 16, width of retire_count and overrun_count

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
instr_valid  input  1  execute stage retired an instruction this cycle
instr  input  12  retired PDP-8 instruction word
hist_flush  input  1  synchronous clear of history and counters
obs_clear  input  1  consumer acknowledges the current observation
obs_flag  output  1  unconsumed observation pending
hist_flat  output  4*DEPTH  class history; [3:0] newest, [4*DEPTH-1:4*DEPTH-4] oldest
hist_count  output  5  valid entries, saturates at DEPTH
last_class  output  4  class of the most recent capture (equals hist_flat[3:0])
retire_count  output  CNT_W  captured retirements, wraps
overrun_count  output  CNT_W  overruns, saturates at all-ones

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, on reset_n. While reset_n is low, every output is 0 and every history entry is 0.
- Classification (combinational on instr; op = instr[11:9]):
  - op 0..6 map to AND=0, TAD=1, ISZ=2, DCA=3, JMS=4, JMP=5, IOT=6.
  - op 7 with instr[8]=0 (group 1): 7000 -> NOP=7; 7300 -> CLA_CLL=8; otherwise OPR1=10.
  - op 7 with instr[8]=1, instr[0]=0 (group 2): 7402 -> HLT=9; otherwise OPR2=11.
  - op 7 with instr[8]=1, instr[0]=1: OPR3=12.
  - Codes 13..15 are never produced.
- Capture (rising edge with instr_valid=1 and hist_flush=0):
  - Shift history one entry toward the oldest position; the new class enters entry 0 and the oldest entry is discarded.
  - hist_count increments up to DEPTH, then holds.
  - retire_count increments, wrapping from all-ones to 0.
  - last_class updates.
  - Latency: outputs reflect the capture on the edge after instr_valid is sampled (one cycle).
- Observation handshake:
  - obs_flag goes to 1 on every capture.
  - obs_clear=1 with no capture in the same cycle: obs_flag goes to 0.
  - Capture while obs_flag=1 and obs_clear=0: overrun. overrun_count increments (saturating) and obs_flag stays 1. History still shifts; it is never stalled.
  - Capture and obs_clear in the same cycle: the clear applies to the old observation, no overrun is counted, and obs_flag stays 1 for the new one.
  - obs_clear while obs_flag=0: no effect.
- Flush:
  - hist_flush=1 zeroes history, hist_count, last_class, retire_count, overrun_count and obs_flag on the next edge.
  - Flush has priority over a simultaneous capture; that instruction is dropped and counts nothing.
- Back-to-back: instr_valid may be high every cycle; every cycle captures.
- Reset mid-operation: immediate clear. Captures resume on the first edge after reset_n deasserts.
- hist_count is 5 bits because DEPTH can be 16.

Test Plan:
- Reset, then retire 7300,1010,1011,3012,7402,5200 on consecutive cycles, pulsing obs_clear the cycle after each capture -> hist_flat nibbles newest-to-oldest = 5,9,3,1,1,8; hist_count=6; retire_count=6; overrun_count=0; obs_flag=0 after the final clear.
- Classify each of 0000,2000,4000,6031,7000,7001,7402,7410,7401 -> 0,2,4,6,7,10,9,11,12 respectively.
- Ten captures with DEPTH=6 -> hist_count=6; hist_flat holds only the last six classes; oldest entries dropped in order.
- Three back-to-back captures with obs_clear held low -> overrun_count=2, obs_flag=1. Then capture with obs_clear=1 in the same cycle -> overrun_count remains 2, obs_flag=1. Then obs_clear alone -> obs_flag=0.
- hist_flush asserted concurrently with instr_valid (instr=5200) after four captures -> all outputs 0 on the next edge; the following capture of 1000 gives hist_count=1, last_class=1, retire_count=1.
- Drop reset_n mid-stream asynchronously (between edges) with obs_flag=1 -> outputs 0 immediately, before the next clock edge. Captures resume correctly after release; retire_count restarts from 1.
